sram_controller: RTL
====================

# sram_controller

Data-memory responder for the five-stage ARM pipeline. It accepts the MEM stage's 32-bit word read/write requests and serves each one as two 16-bit accesses to an external single-port SRAM. While a transaction is in progress it holds `ready` low, and the core's global freeze logic stalls the pipeline on that signal. It replaces the single-cycle data memory behind the MEM stage.

## Interface
Parameters:
- `SRAM_WAIT`, default 2: cycles per 16-bit phase; minimum legal value is 2.
- `ADDR_BASE`, default 1024: byte address that maps to SRAM word 0.

Ports:
- `clk` in 1: single clock; every register updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `wr_en` in 1: store request from the MEM stage.
- `rd_en` in 1: load request from the MEM stage.
- `address` in 32: byte address, i.e. the ALU result.
- `write_data` in 32: store data, i.e. the Rm value.
- `read_data` out 32: load result, registered.
- `ready` out 1: high means the pipeline may advance; low means freeze.
- `sram_addr` out 18: SRAM halfword address.
- `sram_dq_out` out 16: SRAM write data.
- `sram_dq_oe` out 1: drive enable for the external tri-state DQ buffer.
- `sram_dq_in` in 16: SRAM read data.
- `sram_we_n` out 1: SRAM write strobe, active-low.

## Operation
- States: IDLE, LOW, HIGH, DONE.
- Request capture (IDLE, `wr_en|rd_en` = 1):
  - Latch op, `address` and `write_data`.
  - Next state is LOW, with the phase counter cleared.
  - If `wr_en` and `rd_en` are both high, the write wins and the read is ignored.
- Address mapping:
  - off = `address` − `ADDR_BASE`, computed as a 32-bit subtraction with wrap-around.
  - word = off[18:2].
  - LOW phase: `sram_addr` = {word, 0}.
  - HIGH phase: `sram_addr` = {word, 1}.
  - off[1:0] is ignored. Out-of-range addresses alias by truncation; no error is flagged.
- Halfword order: LOW phase carries data bits [15:0]; HIGH phase carries bits [31:16].
- Phase counter runs 0..`SRAM_WAIT`−1 in LOW and again in HIGH.
- LOW → HIGH and HIGH → DONE transitions happen at count `SRAM_WAIT`−1.
- DONE → IDLE after exactly one cycle, unconditionally.
- Write phases:
  - `sram_dq_oe` = 1 and `sram_dq_out` = the selected halfword for the whole phase.
  - `sram_we_n` = 0 while count < `SRAM_WAIT`−1, and 1 on the last cycle of the phase. This keeps the address stable across the we_n rising edge.
- Read phases:
  - `sram_dq_oe` = 0 and `sram_we_n` = 1.
  - `sram_dq_in` is captured on the last cycle of each phase: LOW fills `read_data`[15:0], HIGH fills [31:16].
- `read_data` holds its value until the next read updates it; writes never change it.
- `ready`:
  - IDLE: `ready` = ~(`wr_en`|`rd_en`). This is combinational, so the freeze begins in the same cycle as the request.
  - LOW and HIGH: 0.
  - DONE: 1.
- Request inputs are ignored in LOW, HIGH and DONE; the transaction completes with the latched values. DONE never captures a new request, so the next instruction's request is seen in IDLE.
- Outside a transaction (IDLE, DONE): `sram_we_n` = 1, `sram_dq_oe` = 0, `sram_addr` holds its last value.

## Timing
- Reset values: state IDLE, counter 0, `read_data` 0, `sram_addr` 0, `sram_dq_out` 0, `sram_dq_oe` 0, `sram_we_n` 1. `ready` = 1 when no request is present.
- Let the request be seen in IDLE at cycle 0:
  - LOW occupies cycles 1..W.
  - HIGH occupies cycles W+1..2W.
  - DONE is cycle 2W+1, with `ready` = 1.
  - `ready` is low for 2W+1 cycles, which is 5 for W = 2.
- Read latency: the full 32-bit `read_data` is valid from cycle 2W+1, while `ready` is high. The MEM stage register samples it at the end of that cycle.
- Back-to-back requests: the earliest next capture is cycle 2W+2, so throughput is one word per 2W+2 cycles.
- `rst` asserted in any state aborts the transaction at the next edge:
  - All outputs return to their reset values next cycle.
  - No partial `read_data` update is kept.
  - A write may be left half-done in SRAM; this is accepted.

## Test plan
- Reset idle: assert `rst` 2 cycles with no request → `ready` = 1, `sram_we_n` = 1, `sram_dq_oe` = 0, `read_data` = 0.
- Single write, W = 2: `address` = 1032, `write_data` = 0xDEADBEEF, `wr_en` pulse →
  - `sram_addr` = 4 with `sram_dq_out` = 0xBEEF during cycles 1–2, then `sram_addr` = 5 with `sram_dq_out` = 0xDEAD during cycles 3–4.
  - `sram_we_n` is low on cycles 1 and 3 only.
  - `ready` is low on cycles 0–4 and high on cycle 5.
- Readback: SRAM model returns stored halfwords; `rd_en` at 1032 → `read_data` = 0xDEADBEEF at cycle 5, `sram_dq_oe` = 0 throughout.
- Simultaneous `wr_en`/`rd_en` at 1024 with data 0x12345678 → write performed to SRAM addresses 0/1, and `read_data` keeps its prior value.
- Inputs change mid-transaction: `address` altered on cycle 2 → `sram_addr` sequence is unchanged.
- Reset mid-read: `rst` asserted on cycle 3 of a read → state IDLE next cycle, `read_data` = 0. A following read of 1036 then completes normally in 5 cycles.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller: serves 32-bit MEM-stage word loads/stores as two 16-bit
// accesses (low halfword, then high halfword) to an external single-port SRAM.
// While a transaction runs, ready is held low so the pipeline freezes.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en, rd_en      store / load request (store wins if both are set)
//   address           byte address (ALU result)
//   write_data        store data
//   read_data         registered load result
//   ready             1 = pipeline may advance, 0 = freeze
//   sram_addr         SRAM halfword address
//   sram_dq_out       SRAM write data
//   sram_dq_oe        drive enable for the external DQ tri-state buffer
//   sram_dq_in        SRAM read data
//   sram_we_n         SRAM write strobe, active-low
module sram_controller #(
  parameter int          SRAM_WAIT = 2,
  parameter logic [31:0] ADDR_BASE = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  // Latched request, held for the whole transaction.
  typedef struct packed {
    logic        is_wr;
    logic [16:0] word;
    logic [31:0] wdata;
  } req_t;

  localparam int             CW   = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
  localparam logic [CW-1:0]  LAST = CW'(SRAM_WAIT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  req_t          req;

  // Only bits [18:2] of the offset are used, and the low bits of a
  // subtraction depend only on the low bits of its operands.
  logic [18:0]   off_lo;
  logic [CW-1:0] cnt_nxt;
  logic          cnt_last;
  logic          unused_bits;

  assign off_lo      = address[18:0] - ADDR_BASE[18:0];
  assign cnt_nxt     = cnt + CW'(1);
  assign cnt_last    = (cnt == LAST);
  assign unused_bits = ^{address[31:19], off_lo[1:0]};

  // Combinational in IDLE so the freeze starts in the request cycle.
  assign ready = (state == IDLE) ? ~(wr_en | rd_en) : (state == DONE);

  // Outputs are registered for the state being entered, so the SRAM sees a
  // stable address/data for every cycle of a phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      req         <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en | rd_en) begin
            state       <= LOW;
            cnt         <= '0;
            req.is_wr   <= wr_en;
            req.word    <= off_lo[18:2];
            req.wdata   <= write_data;
            sram_addr   <= {off_lo[18:2], 1'b0};
            sram_dq_out <= write_data[15:0];
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
          end
        end
        LOW, HIGH: begin
          if (!cnt_last) begin
            cnt <= cnt_nxt;
            // Release we_n one cycle before the address moves.
            if (cnt_nxt == LAST) sram_we_n <= 1'b1;
          end else begin
            cnt <= '0;
            if (!req.is_wr) begin
              if (state == LOW) read_data[15:0]  <= sram_dq_in;
              else              read_data[31:16] <= sram_dq_in;
            end
            if (state == LOW) begin
              state       <= HIGH;
              sram_addr   <= {req.word, 1'b1};
              sram_dq_out <= req.wdata[31:16];
              sram_dq_oe  <= req.is_wr;
              sram_we_n   <= ~req.is_wr;
            end else begin
              state      <= DONE;
              sram_dq_oe <= 1'b0;
              sram_we_n  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;  // DONE: one cycle with ready high
      endcase
    end
  end

endmodule
